// File: rtl/sram_like_pkg.sv
// Shared types and helpers for the SRAM-like memory responder.
// Size codes, lane mask helper, queue entry layout and LFSR constants.
package sram_like_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  // Wide enough for LATENCY-1 plus up to 3 random stall cycles.
  localparam int WAIT_W = 5;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Taps 16,14,13,11 as bit positions 15,13,12,10.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef struct packed {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  function automatic logic [3:0] byte_mask(
    input logic [1:0] sz,
    input logic [1:0] lo
  );
    case (sz)
      SZ_BYTE: byte_mask = 4'b0001 << lo;
      SZ_HALF: byte_mask = lo[1] ? 4'b1100 : 4'b0011;
      default: byte_mask = 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/sram_req_queue.sv
// In-order request FIFO with a per-entry wait counter that ages each cycle.
// Ports: i_push/i_data/i_wait in, i_pop in, o_full/o_empty/o_head/o_head_ready out.
module sram_req_queue
  import sram_like_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_push,
  input  logic              i_pop,
  input  req_t              i_data,
  input  logic [WAIT_W-1:0] i_wait,
  output logic              o_full,
  output logic              o_empty,
  output req_t              o_head,
  output logic              o_head_ready
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] CNT_ONE  = (PW+1)'(1);
  localparam logic [PW:0] CNT_FULL = (PW+1)'(DEPTH);

  req_t              r_ent  [DEPTH];
  logic [WAIT_W-1:0] r_wait [DEPTH];
  logic [PW-1:0]     r_rd;
  logic [PW-1:0]     r_wr;
  logic [PW:0]       r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd  <= '0;
      r_wr  <= '0;
      r_cnt <= '0;
    end else begin
      if (i_push) r_wr <= r_wr + 1'b1;
      if (i_pop)  r_rd <= r_rd + 1'b1;
      case ({i_push, i_pop})
        2'b10:   r_cnt <= r_cnt + CNT_ONE;
        2'b01:   r_cnt <= r_cnt - CNT_ONE;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // Free slots keep aging too; harmless since a push overwrites them.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (rst) begin
        r_wait[i] <= '0;
      end else if (i_push && r_wr == PW'(i)) begin
        r_wait[i] <= i_wait;
      end else if (r_wait[i] != '0) begin
        r_wait[i] <= r_wait[i] - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (i_push && r_wr == PW'(i)) r_ent[i] <= i_data;
    end
  end

  assign o_empty      = (r_cnt == '0);
  // A pop in the same cycle frees a slot for a simultaneous push.
  assign o_full       = (r_cnt == CNT_FULL) & ~i_pop;
  assign o_head       = r_ent[r_rd];
  assign o_head_ready = ~o_empty & (r_wait[r_rd] == '0);

endmodule

// File: rtl/sram_like_mem_responder.sv
// SRAM-like slave: word memory, byte-masked writes, fixed latency, in-order queue.
// Ports: clk, rst, req/wr/size/addr/wdata in; addr_ok/data_ok/rdata out. Option: RANDOM_STALL_EN.
module sram_like_mem_responder
  import sram_like_pkg::*;
#(
  parameter int ADDR_W  = 12,
  parameter int LATENCY = 2,
  parameter int DEPTH   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rdata
);

  logic              w_full;
  logic              w_empty;
  logic              w_ready;
  logic              w_pop;
  logic              w_gate;
  logic [WAIT_W-1:0] w_wait;
  req_t              w_new;
  req_t              w_head;
  logic [ADDR_W-1:0] w_idx;
  logic [3:0]        w_mask;
  logic              w_unused;

  logic [31:0]       r_mem [2**ADDR_W];
  logic [31:0]       r_rdata;

`ifdef RANDOM_STALL_EN
  logic [15:0] r_lfsr;

  always_ff @(posedge clk) begin
    if (rst) r_lfsr <= LFSR_SEED;
    else     r_lfsr <= {r_lfsr[14:0], ^(r_lfsr & LFSR_TAPS)};
  end

  assign w_gate = ~r_lfsr[0];
  assign w_wait = WAIT_W'(LATENCY - 1) + WAIT_W'(r_lfsr[3:2]);
`else
  assign w_gate = 1'b1;
  assign w_wait = WAIT_W'(LATENCY - 1);
`endif

  assign w_new   = {wr, size, addr, wdata};
  assign addr_ok = req & ~w_full & ~rst & w_gate;
  assign w_pop   = w_ready & ~rst;
  assign data_ok = w_pop;

  sram_req_queue #(
    .DEPTH(DEPTH)
  ) u_queue (
    .clk         (clk),
    .rst         (rst),
    .i_push      (addr_ok),
    .i_pop       (w_pop),
    .i_data      (w_new),
    .i_wait      (w_wait),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_head      (w_head),
    .o_head_ready(w_ready)
  );

  // Upper address bits alias; only the word index selects storage.
  assign w_idx    = w_head.addr[ADDR_W+1:2];
  assign w_mask   = byte_mask(w_head.size, w_head.addr[1:0]);
  assign w_unused = ^{w_head.addr[31:ADDR_W+2], w_empty};

  always_ff @(posedge clk) begin
    if (w_pop && w_head.wr) begin
      for (int b = 0; b < 4; b++) begin
        if (w_mask[b]) r_mem[w_idx][8*b +: 8] <= w_head.wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)        r_rdata <= '0;
    else if (w_pop) r_rdata <= r_mem[w_idx];
  end

  assign rdata = rst ? '0 : (w_pop ? r_mem[w_idx] : r_rdata);

endmodule

// File: tb/tb_sram_like_mem_responder.sv
// Self-checking bench for sram_like_mem_responder.
// Instance 0: LATENCY=2 DEPTH=2; instance 1: LATENCY=4 DEPTH=2 for backpressure.
module tb_sram_like_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        sel;

  logic        ok0, dok0, ok1, dok1;
  logic [31:0] rd0, rd1;
  logic        addr_ok, data_ok;
  logic [31:0] rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sram_like_mem_responder #(
    .ADDR_W(12), .LATENCY(2), .DEPTH(2)
  ) u_dut (
    .clk    (clk),
    .rst    (rst),
    .req    (req & ~sel),
    .wr     (wr),
    .size   (size),
    .addr   (addr),
    .wdata  (wdata),
    .addr_ok(ok0),
    .data_ok(dok0),
    .rdata  (rd0)
  );

  sram_like_mem_responder #(
    .ADDR_W(12), .LATENCY(4), .DEPTH(2)
  ) u_bp (
    .clk    (clk),
    .rst    (rst),
    .req    (req & sel),
    .wr     (wr),
    .size   (size),
    .addr   (addr),
    .wdata  (wdata),
    .addr_ok(ok1),
    .data_ok(dok1),
    .rdata  (rd1)
  );

  assign addr_ok = sel ? ok1 : ok0;
  assign data_ok = sel ? dok1 : dok0;
  assign rdata   = sel ? rd1 : rd0;

  typedef struct {
    logic        w;
    logic [1:0]  sz;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] exp;
  } vec_t;

  typedef struct {
    logic        w;
    logic [31:0] exp;
    int          t;
  } pend_t;

  localparam int NV = 15;
  vec_t  vt [NV];
  pend_t pq [$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_lat(input string nm, input int lat, input int base);
    checks++;
`ifdef RANDOM_STALL_EN
    if (lat < base || lat > base + 3) begin
      errors++;
      $display("FAIL %s latency: got %0d expected %0d..%0d",
               nm, lat, base, base + 3);
    end
`else
    if (lat != base) begin
      errors++;
      $display("FAIL %s latency: got %0d expected %0d", nm, lat, base);
    end
`endif
  endtask

  task automatic txn(input logic w, input logic [1:0] sz,
                     input logic [31:0] a, input logic [31:0] d,
                     input logic [31:0] exp, input int base,
                     input string nm);
    int n;
    int lat;
    @(negedge clk);
    req = 1'b1; wr = w; size = sz; addr = a; wdata = d;
    n = 0;
    #1;
    while (!addr_ok && n < 64) begin
      @(negedge clk); #1; n++;
    end
    chk({nm, " accept"}, 32'(addr_ok), 32'd1);
    @(negedge clk);
    req = 1'b0;
    lat = 1;
    #1;
    while (!data_ok && lat < 40) begin
      @(negedge clk); #1; lat++;
    end
    chk({nm, " data_ok"}, 32'(data_ok), 32'd1);
    chk_lat(nm, lat, base);
    if (!w) chk({nm, " rdata"}, rdata, exp);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n, k, r, seen, issued, widx, lo;
    bit hold, en;
    int acc [4];
    int rsp [4];
    logic [31:0] mdl [16];
    logic [31:0] e;
    pend_t p;

    rst = 1'b1; req = 1'b0; wr = 1'b0; size = '0;
    addr = '0; wdata = '0; sel = 1'b0;

    vt[0]  = '{1'b1, 2'd2, 32'h10,   32'hDEADBEEF, 32'h0};
    vt[1]  = '{1'b0, 2'd2, 32'h10,   32'h0,        32'hDEADBEEF};
    vt[2]  = '{1'b1, 2'd2, 32'h20,   32'h00000000, 32'h0};
    vt[3]  = '{1'b1, 2'd0, 32'h23,   32'hAB000000, 32'h0};
    vt[4]  = '{1'b1, 2'd1, 32'h20,   32'h00001234, 32'h0};
    vt[5]  = '{1'b0, 2'd2, 32'h20,   32'h0,        32'hAB001234};
    vt[6]  = '{1'b1, 2'd2, 32'h24,   32'hFFFFFFFF, 32'h0};
    vt[7]  = '{1'b1, 2'd1, 32'h27,   32'h56780000, 32'h0};
    vt[8]  = '{1'b0, 2'd2, 32'h24,   32'h0,        32'h5678FFFF};
    vt[9]  = '{1'b1, 2'd2, 32'h31,   32'h01020304, 32'h0};
    vt[10] = '{1'b0, 2'd2, 32'h30,   32'h0,        32'h01020304};
    vt[11] = '{1'b0, 2'd2, 32'h4020, 32'h0,        32'hAB001234};
    vt[12] = '{1'b1, 2'd3, 32'h30,   32'hCAFEF00D, 32'h0};
    vt[13] = '{1'b1, 2'd0, 32'h31,   32'h0000EE00, 32'h0};
    vt[14] = '{1'b0, 2'd2, 32'h30,   32'h0,        32'hCAFEEE0D};

    // Reset state, request held high during reset.
    @(negedge clk);
    req = 1'b1;
    #1;
    chk("rst addr_ok", 32'(addr_ok), 32'd0);
    chk("rst data_ok", 32'(data_ok), 32'd0);
    chk("rst rdata", rdata, 32'h0);
    @(negedge clk);
    rst = 1'b0; req = 1'b0;
    #1;
    chk("post-rst addr_ok", 32'(addr_ok), 32'd0);
    chk("post-rst data_ok", 32'(data_ok), 32'd0);
    chk("post-rst rdata", rdata, 32'h0);

    // Table-driven single transactions.
    for (int i = 0; i < NV; i++)
      txn(vt[i].w, vt[i].sz, vt[i].a, vt[i].d, vt[i].exp, 2,
          $sformatf("vec%0d", i));

    @(negedge clk);
    #1;
    chk("hold data_ok", 32'(data_ok), 32'd0);
    chk("hold rdata", rdata, vt[NV-1].exp);

    // Read-after-write accepted back to back.
    txn(1'b1, 2'd2, 32'h40, 32'hFFFFFFFF, 32'h0, 2, "raw pre");
    k = 0; r = 0;
    @(negedge clk);
    for (int c = 0; c < 60 && r < 2; c++) begin
      req = (k < 2); wr = (k == 0); size = 2'd2;
      addr = 32'h40; wdata = 32'h55;
      #1;
      if (data_ok) begin
        if (r == 1) chk("raw rdata", rdata, 32'h00000055);
        r++;
      end
      if (req && addr_ok) begin
        acc[k] = c; k++;
      end
      @(negedge clk);
    end
    req = 1'b0;
    chk("raw responses", 32'(r), 32'd2);
`ifndef RANDOM_STALL_EN
    chk("raw consecutive", 32'(acc[1] - acc[0]), 32'd1);
`endif

    // Backpressure on the LATENCY=4 instance.
    sel = 1'b1;
    for (int i = 0; i < 4; i++)
      txn(1'b1, 2'd2, 32'h200 + 32'(4 * i), 32'h10000000 + 32'(i),
          32'h0, 4, $sformatf("bp fill%0d", i));
    k = 0; r = 0;
    @(negedge clk);
    for (int c = 0; c < 80 && r < 4; c++) begin
      req = (k < 4); wr = 1'b0; size = 2'd2;
      addr = 32'h200 + 32'(4 * k);
      #1;
      if (data_ok) begin
        chk($sformatf("bp rdata%0d", r), rdata, 32'h10000000 + 32'(r));
        rsp[r] = c; r++;
      end
      if (req && addr_ok) begin
        acc[k] = c; k++;
      end
      @(negedge clk);
    end
    req = 1'b0;
    chk("bp responses", 32'(r), 32'd4);
`ifndef RANDOM_STALL_EN
    chk("bp acc1", 32'(acc[1]), 32'd1);
    chk("bp acc2 stalled", 32'(acc[2]), 32'd4);
    chk("bp acc2 on first pop", 32'(acc[2]), 32'(rsp[0]));
    chk("bp acc3", 32'(acc[3]), 32'd5);
    chk("bp rsp3", 32'(rsp[3]), 32'd9);
`endif
    @(negedge clk);
    sel = 1'b0;

    // Reset while a write is outstanding.
    txn(1'b1, 2'd2, 32'h80, 32'h2222, 32'h0, 2, "rmf pre");
    @(negedge clk);
    req = 1'b1; wr = 1'b1; size = 2'd2; addr = 32'h80; wdata = 32'h1111;
    n = 0;
    #1;
    while (!addr_ok && n < 64) begin
      @(negedge clk); #1; n++;
    end
    chk("rmf accept", 32'(addr_ok), 32'd1);
    @(negedge clk);
    req = 1'b0; rst = 1'b1; seen = 0;
    for (int c = 0; c < 2; c++) begin
      #1;
      if (data_ok) seen = 1;
      @(negedge clk);
    end
    rst = 1'b0;
    for (int c = 0; c < 8; c++) begin
      #1;
      if (data_ok) seen = 1;
      @(negedge clk);
    end
    chk("rmf no data_ok", 32'(seen), 32'd0);
    txn(1'b0, 2'd2, 32'h80, 32'h0, 32'h2222, 2, "rmf read");

    // Random pipelined traffic against a scoreboard.
    for (int i = 0; i < 16; i++) begin
      txn(1'b1, 2'd2, 32'h400 + 32'(4 * i), 32'h0, 32'h0, 2, "rnd init");
      mdl[i] = 32'h0;
    end
    issued = 0; hold = 0; widx = 0; lo = 0;
    @(negedge clk);
    for (int c = 0; c < 4000 && (issued < 200 || pq.size() > 0); c++) begin
      if (!hold) begin
        req = 1'b0;
        if (issued < 200 && $urandom_range(3) != 0) begin
          req = 1'b1; hold = 1;
          wr = 1'($urandom_range(1));
          size = 2'($urandom_range(3));
          widx = $urandom_range(15);
          lo = $urandom_range(3);
          addr = 32'(32'h400 + widx * 4 + lo);
          wdata = $urandom;
        end
      end
      #1;
      if (data_ok) begin
        if (pq.size() == 0) begin
          checks++; errors++;
          $display("FAIL rnd: data_ok with nothing outstanding");
        end else begin
          p = pq.pop_front();
          chk_lat("rnd", c - p.t, 2);
          if (!p.w) chk("rnd rdata", rdata, p.exp);
        end
      end
      if (req && addr_ok) begin
        e = mdl[widx];
        if (wr) begin
          for (int b = 0; b < 4; b++) begin
            case (size)
              2'd0:    en = (b == lo);
              2'd1:    en = (b / 2 == lo / 2);
              default: en = 1'b1;
            endcase
            if (en) mdl[widx][8*b +: 8] = wdata[8*b +: 8];
          end
        end
        pq.push_back('{wr, e, c});
        issued++; hold = 0;
      end
      @(negedge clk);
    end
    req = 1'b0;
    chk("rnd issued", 32'(issued), 32'd200);
    chk("rnd drained", 32'(pq.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
